// File: rtl/uart_axis_fifo.sv
// First-word-fall-through AXI-Stream byte FIFO with a registered output stage.
// Define UART_FIFO_LEVEL_EN to expose the registered occupancy count on the level port.
module uart_axis_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  full,
  output logic                  empty
`ifdef UART_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   level
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  push_s, pop_s, load_s, mem_empty_s, mem_we_s;

  // The array never holds more than DEPTH-1 words (one lives in the output
  // register), so pointer equality alone means the array is empty.
  assign mem_empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full          = (count_q == CNT_FULL);
  assign empty         = (count_q == CNT_ZERO);
  assign s_axis_tready = ~full;
  assign push_s        = s_axis_tvalid & ~full;
  assign pop_s         = out_valid_q & m_axis_tready;
  assign load_s        = ~out_valid_q | pop_s;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
`ifdef UART_FIFO_LEVEL_EN
  assign level         = count_q;
`endif

  // Next-state: output-register reload, pointer advance and occupancy update.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_we_s    = 1'b0;
    if (load_s) begin
      if (!mem_empty_s) begin
        out_data_d  = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        mem_we_s    = push_s;
      end else if (push_s) begin
        // Nothing stored ahead of it: the incoming word goes straight to the output.
        out_data_d  = s_axis_tdata;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      mem_we_s = push_s;
    end
    if (mem_we_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      out_data_q  <= DATA_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_uart_axis_fifo.sv
// Self-checking bench for uart_axis_fifo: queue model checked every cycle plus directed literals.
module tb_uart_axis_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       full;
  logic       empty;
`ifdef UART_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  logic [7:0] exp_q[$];

  uart_axis_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .full(full), .empty(empty)
`ifdef UART_FIFO_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a plain queue, updated on each clock edge.
  always @(posedge clk) begin : model
    bit pu, po;
    if (reset) begin
      mq.delete();
    end else begin
      pu = s_tvalid && (mq.size() < 16);
      po = m_tready && (mq.size() > 0);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(s_tdata);
    end
  end

  // Compare outputs against the model, and log words handed to the consumer.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
      chk("full", {31'd0, full}, {31'd0, mq.size() == 16});
      chk("s_tready", {31'd0, s_tready}, {31'd0, mq.size() != 16});
      chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) chk("m_tdata", {24'd0, m_tdata}, {24'd0, mq[0]});
`ifdef UART_FIFO_LEVEL_EN
      chk("level", {27'd0, level}, mq.size());
`endif
    end
    if (!reset && m_tvalid && m_tready) popped.push_back(m_tdata);
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic check_seq(input string name);
    chk({name, "_count"}, popped.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
      chk(name, {24'd0, popped[i]}, {24'd0, exp_q[i]});
    popped.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
    @(posedge clk); #2;
    cyc(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, m_tdata}, 32'h00);
    chk("rst_tready", {31'd0, s_tready}, 32'd1);

    // Test 1: single word, held while the consumer stalls
    cyc(1'b1, 8'h41, 1'b0);
    chk("t1_tready", {31'd0, s_tready}, 32'd1);
    chk("t1_tvalid", {31'd0, m_tvalid}, 32'd1);
    chk("t1_tdata", {24'd0, m_tdata}, 32'h41);
    chk("t1_empty", {31'd0, empty}, 32'd0);
`ifdef UART_FIFO_LEVEL_EN
    chk("t1_level", {27'd0, level}, 32'd1);
`endif
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      chk("t1_hold", {23'd0, m_tvalid, m_tdata}, 32'h141);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("t1_empty_after", {31'd0, empty}, 32'd1);
    exp_q.push_back(8'h41);
    check_seq("t1_seq");

    // Test 2: fill to full, rejected 17th write, ordered drain
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_tready", {31'd0, s_tready}, 32'd0);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("t2_still_full", {31'd0, full}, 32'd1);
    chk("t2_head", {24'd0, m_tdata}, 32'h00);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("t2_empty", {31'd0, empty}, 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    check_seq("t2_seq");

    // Test 3: pointer wrap-around
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
    popped.delete();
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h80 + 8'(i));
    check_seq("t3_seq");

    // Test 4: simultaneous push/pop at level 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b1);
    chk("t4_not_empty", {31'd0, empty}, 32'd0);
    chk("t4_not_full", {31'd0, full}, 32'd0);
    chk("t4_head", {24'd0, m_tdata}, 32'hBF);
`ifdef UART_FIFO_LEVEL_EN
    chk("t4_level", {27'd0, level}, 32'd5);
`endif
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 20; i++) exp_q.push_back(8'hB0 + 8'(i));
    check_seq("t4_seq");

    // Test 5: transmitter-paced drain, one ready pulse every 10 cycles
    for (int i = 0; i < 90; i++) begin
      cyc(i < 8, 8'hC0 + 8'(i), (i % 10) == 9);
      if ((i % 10) == 9) chk("t5_per_pulse", popped.size(), (i < 80) ? (i + 1) / 10 : 8);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(8'hC0 + 8'(i));
    check_seq("t5_seq");

    // Test 6: reset mid-operation discards data and an in-flight push
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0);
    reset = 1'b1;
    cyc(1'b1, 8'h99, 1'b0);
    reset = 1'b0;
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("t6_tdata", {24'd0, m_tdata}, 32'h00);
`ifdef UART_FIFO_LEVEL_EN
    chk("t6_level", {27'd0, level}, 32'd0);
`endif
    cyc(1'b1, 8'h55, 1'b0);
    chk("t6_fresh", {23'd0, m_tvalid, m_tdata}, 32'h155);
    cyc(1'b0, 8'h00, 1'b1);
    exp_q.push_back(8'h55);
    check_seq("t6_seq");

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
